// File: rtl/wb_register_file_if.sv
// Write-back / decode bundle for the architectural register file.
// The master side is the pipeline: write-back, decode and issue. The slave side is the register file.
interface wb_register_file_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
    logic                  Write_Enable;
    logic [ADDR_WIDTH-1:0] Write_Register_Num;
    logic [DATA_WIDTH-1:0] Write_Data;
    logic                  Read_Valid;
    logic [ADDR_WIDTH-1:0] Read_Reg_Num1;
    logic [ADDR_WIDTH-1:0] Read_Reg_Num2;
    logic [DATA_WIDTH-1:0] Read_Data1;
    logic [DATA_WIDTH-1:0] Read_Data2;
    logic                  Issue_Valid;
    logic [ADDR_WIDTH-1:0] Issue_Dest;
    logic                  Stall;

    modport master (
        output Write_Enable, Write_Register_Num, Write_Data,
        output Read_Valid, Read_Reg_Num1, Read_Reg_Num2,
        output Issue_Valid, Issue_Dest,
        input  Read_Data1, Read_Data2, Stall
    );

    modport slave (
        input  Write_Enable, Write_Register_Num, Write_Data,
        input  Read_Valid, Read_Reg_Num1, Read_Reg_Num2,
        input  Issue_Valid, Issue_Dest,
        output Read_Data1, Read_Data2, Stall
    );
endinterface

// File: rtl/wb_register_file.sv
// Architectural register file with two registered read ports and write-through bypass.
// A per-register pending scoreboard stalls decode while a source operand awaits write-back.
module wb_register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8
) (
    input logic             clk,
    input logic             reset,
    wb_register_file_if.slave bus
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;
    logic [DATA_WIDTH-1:0] rd_data1_p1;
    logic [DATA_WIDTH-1:0] rd_data2_p1;
    logic                  wr_hit1;
    logic                  wr_hit2;
    logic                  haz1;
    logic                  haz2;
    logic                  stall;

    // A write landing this cycle satisfies a pending operand through the bypass.
    always_comb begin
        wr_hit1 = bus.Write_Enable && (bus.Write_Register_Num == bus.Read_Reg_Num1);
        wr_hit2 = bus.Write_Enable && (bus.Write_Register_Num == bus.Read_Reg_Num2);
        haz1    = pending[bus.Read_Reg_Num1] && !wr_hit1;
        haz2    = pending[bus.Read_Reg_Num2] && !wr_hit2;
        stall   = bus.Read_Valid && (haz1 || haz2);
    end

    // Clear the bit first, then set it, so that a same-cycle issue (the newer producer) wins.
    always_comb begin
        pending_nxt = pending;
        if (bus.Write_Enable) begin
            pending_nxt[bus.Write_Register_Num] = 1'b0;
        end
        if (bus.Issue_Valid && !stall) begin
            pending_nxt[bus.Issue_Dest] = 1'b1;
        end
    end

    // Stage boundary: register array, scoreboard and read operands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
            pending     <= '0;
            rd_data1_p1 <= '0;
            rd_data2_p1 <= '0;
        end else begin
            if (bus.Write_Enable) begin
                regs[bus.Write_Register_Num] <= bus.Write_Data;
            end
            pending     <= pending_nxt;
            rd_data1_p1 <= wr_hit1 ? bus.Write_Data : regs[bus.Read_Reg_Num1];
            rd_data2_p1 <= wr_hit2 ? bus.Write_Data : regs[bus.Read_Reg_Num2];
        end
    end

    assign bus.Read_Data1 = rd_data1_p1;
    assign bus.Read_Data2 = rd_data2_p1;
    assign bus.Stall      = stall;

endmodule
